rv_inst_encoder: RTL

- Converts structured instruction requests (format kind, register indices, funct3, alt bit, 32-bit immediate) into 32-bit RV32I instruction words.
- It is the encode-side counterpart of the opcode/funct3 decode definitions. It feeds the debug program buffer and the self-test instruction injector.
- Expands the LI pseudo-op into LUI+ADDI, so one request may yield one or two output words.
- Output is registered, with a valid/ready handshake on both sides.

---
 rtl/rv_inst_encoder_pkg.sv | 53 +++++
 rtl/rv_inst_encoder_pack.sv | 37 +++
 rtl/rv_inst_encoder.sv | 125 ++++++++++++
 3 files changed

// File: rtl/rv_inst_encoder_pkg.sv
// rv_inst_encoder_pkg: request kinds, RV32I opcodes/funct3 values and encoder helpers.
package rv_inst_encoder_pkg;

    typedef enum logic [3:0] {R_OP, I_OP, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, LI} enc_kind_e;
    typedef enum logic [1:0] {IDLE, EMIT, EMIT2} enc_state_e;

    localparam logic [4:0] G_LOAD   = 5'b00000;
    localparam logic [4:0] G_OP_IMM = 5'b00100;
    localparam logic [4:0] G_AUIPC  = 5'b00101;
    localparam logic [4:0] G_STORE  = 5'b01000;
    localparam logic [4:0] G_OP     = 5'b01100;
    localparam logic [4:0] G_LUI    = 5'b01101;
    localparam logic [4:0] G_BRANCH = 5'b11000;
    localparam logic [4:0] G_JALR   = 5'b11001;
    localparam logic [4:0] G_JAL    = 5'b11011;

    localparam logic [6:0] OPC_LOAD   = {G_LOAD,   2'b11};
    localparam logic [6:0] OPC_OP_IMM = {G_OP_IMM, 2'b11};
    localparam logic [6:0] OPC_AUIPC  = {G_AUIPC,  2'b11};
    localparam logic [6:0] OPC_STORE  = {G_STORE,  2'b11};
    localparam logic [6:0] OPC_OP     = {G_OP,     2'b11};
    localparam logic [6:0] OPC_LUI    = {G_LUI,    2'b11};
    localparam logic [6:0] OPC_BRANCH = {G_BRANCH, 2'b11};
    localparam logic [6:0] OPC_JALR   = {G_JALR,   2'b11};
    localparam logic [6:0] OPC_JAL    = {G_JAL,    2'b11};

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SR  = 3'b101;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    function automatic logic [4:0] gopcode(enc_kind_e k);
        case (k)
            I_OP, LI: return G_OP_IMM;
            LOAD:     return G_LOAD;
            STORE:    return G_STORE;
            BRANCH:   return G_BRANCH;
            JAL:      return G_JAL;
            JALR:     return G_JALR;
            LUI:      return G_LUI;
            AUIPC:    return G_AUIPC;
            default:  return G_OP;
        endcase
    endfunction

    function automatic logic fits_signed(logic [31:0] v, int unsigned n);
        logic [31:0] s;
        s = 32'($signed(v) >>> (n - 1));
        return (s == 32'h0) || (s == 32'hFFFF_FFFF);
    endfunction

endpackage

// File: rtl/rv_inst_encoder_pack.sv
// rv_inst_pack: combinational packing of one request (kind + fields) into an RV32I word.
module rv_inst_pack
    import rv_inst_encoder_pkg::*;
(
    input  logic [3:0]  kind,
    input  logic [2:0]  f3_i,
    input  logic        alt,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word
);

    enc_kind_e  k;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] i_hi;
    logic       shift;

    assign k     = enc_kind_e'(kind);
    assign opc   = {gopcode(k), 2'b11};
    assign f3    = (k == JALR) ? 3'b000 : f3_i;
    // Shift immediates carry only shamt; bit 30 selects arithmetic right shift.
    assign shift = (k == I_OP) && (f3_i == F3_SLL || f3_i == F3_SR);
    assign i_hi  = shift ? {1'b0, alt, 5'b0} : imm[11:5];

    always_comb begin
        word = (k == I_OP || k == LOAD || k == JALR || k == LI) ? {i_hi, imm[4:0], rs1, f3, rd, opc}
             : (k == STORE)  ? {imm[11:5], rs2, rs1, f3, imm[4:0], opc}
             : (k == BRANCH) ? {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc}
             : (k == LUI || k == AUIPC) ? {imm[31:12], rd, opc}
             : (k == JAL)    ? {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc}
             : {1'b0, alt, 5'b0, rs2, rs1, f3, rd, opc};
    end

endmodule

// File: rtl/rv_inst_encoder.sv
// rv_inst_encoder: registered RV32I encoder with LI -> LUI+ADDI expansion.
// Optional RV_ENC_RANGE_CHECK_EN rejects out-of-range immediates and pulses enc_err.
module rv_inst_encoder
    import rv_inst_encoder_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [3:0]      req_kind,
    input  logic [2:0]      req_funct3,
    input  logic            req_alt,
    input  logic [4:0]      req_rd,
    input  logic [4:0]      req_rs1,
    input  logic [4:0]      req_rs2,
    input  logic [XLEN-1:0] req_imm,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic            inst_last,
    output logic            enc_err
);

    enc_state_e  state_q, state_d;
    enc_kind_e   kind;
    logic        valid_q, valid_d, last_q, last_d, err_q, err_d;
    logic [31:0] inst_q, inst_d, pend_q, pend_d;
    logic        is_li, fits12, two, reject, req_hs, out_hs;
    logic [19:0] li_hi;
    logic [3:0]  k0;
    logic [31:0] w0, w1;

    assign kind   = enc_kind_e'(req_kind);
    assign is_li  = (kind == LI);
    assign fits12 = fits_signed(req_imm, 12);
    assign li_hi  = 20'((req_imm + 32'h800) >> 12);
    assign two    = is_li && !fits12 && (req_imm[11:0] != 12'h0);
    assign k0     = !is_li ? req_kind : fits12 ? 4'(I_OP) : 4'(LUI);

    rv_inst_pack u_pack0 (
        .kind (k0),
        .f3_i (is_li ? F3_ADD : req_funct3),
        .alt  (is_li ? 1'b0 : req_alt),
        .rd   (req_rd),
        .rs1  (is_li ? 5'd0 : req_rs1),
        .rs2  (req_rs2),
        .imm  ((is_li && !fits12) ? {li_hi, 12'h0} : req_imm),
        .word (w0)
    );

    rv_inst_pack u_pack1 (
        .kind (4'(I_OP)),
        .f3_i (F3_ADD),
        .alt  (1'b0),
        .rd   (req_rd),
        .rs1  (req_rd),
        .rs2  (5'd0),
        .imm  ({{20{req_imm[11]}}, req_imm[11:0]}),
        .word (w1)
    );

`ifdef RV_ENC_RANGE_CHECK_EN
    assign reject = (kind == I_OP) ? ((req_funct3 == F3_SLL || req_funct3 == F3_SR) ? (req_imm[31:5] != 27'h0) : !fits12)
                  : (kind == LOAD || kind == STORE || kind == JALR) ? !fits12
                  : (kind == BRANCH) ? (!fits_signed(req_imm, 13) || req_imm[0])
                  : (kind == JAL) ? (!fits_signed(req_imm, 21) || req_imm[0])
                  : 1'b0;
`else
    assign reject = 1'b0;
`endif

    // A new request may ride on the handshake of the final word, so IDLE is effectively re-entered then.
    assign req_ready = !valid_q || (inst_ready && last_q);
    assign req_hs    = req_valid && req_ready;
    assign out_hs    = valid_q && inst_ready;

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        inst_d  = inst_q;
        last_d  = last_q;
        pend_d  = pend_q;
        err_d   = 1'b0;
        if (out_hs) begin
            valid_d = (state_q == EMIT) && !last_q;
            inst_d  = ((state_q == EMIT) && !last_q) ? pend_q : inst_q;
            last_d  = ((state_q == EMIT) && !last_q) ? 1'b1 : last_q;
            state_d = ((state_q == EMIT) && !last_q) ? EMIT2 : IDLE;
        end
        if (req_hs) begin
            err_d   = reject;
            valid_d = !reject;
            inst_d  = reject ? inst_d : w0;
            last_d  = reject ? last_d : !two;
            pend_d  = reject ? pend_q : w1;
            state_d = reject ? IDLE : EMIT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            inst_q  <= 32'h0;
            last_q  <= 1'b0;
            pend_q  <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            inst_q  <= inst_d;
            last_q  <= last_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
        end
    end

    assign inst_valid = valid_q;
    assign inst       = inst_q;
    assign inst_last  = last_q;
    assign enc_err    = err_q;

endmodule
